// File: rtl/unified_memory_responder.sv
// Word-addressed unified instruction/data memory for a multicycle controller.
// Accepts one MemRead/MemWrite request at a time and completes it after a fixed wait.
module unified_memory_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        error
);

  localparam int unsigned LP_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LP_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic [31:0]             r_wdata;
  logic                    r_is_write;
  logic                    r_valid;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_error;
  logic [31:0]             r_read_data;
  logic [31:0]             r_mem [LP_DEPTH];

  logic                    w_strobe;
  logic [31:0]             w_hi;
  logic                    w_valid_in;
  logic                    w_is_write_in;
  logic [ADDR_WIDTH-1:0]   w_idx_in;
  logic                    w_fast;
  logic                    w_done_en;
  logic [ADDR_WIDTH-1:0]   w_idx;
  logic [31:0]             w_wdata;
  logic                    w_is_write;
  logic                    w_valid;

  assign w_strobe      = MemRead | MemWrite;
  assign w_hi          = address >> (ADDR_WIDTH + 2);
  assign w_valid_in    = (address[1:0] == 2'b00) && (w_hi == 32'd0) && !(MemRead && MemWrite);
  assign w_is_write_in = MemWrite && !MemRead;
  assign w_idx_in      = address[ADDR_WIDTH+1:2];

  // With zero wait states the access completes on the acceptance edge itself,
  // so the live request is used instead of the latched copy.
  assign w_fast     = (r_state == ST_IDLE) && w_strobe && (LP_WAIT == 4'd0);
  assign w_done_en  = w_fast || ((r_state == ST_BUSY) && (r_cnt == 4'd1));
  assign w_idx      = w_fast ? w_idx_in      : r_idx;
  assign w_wdata    = w_fast ? write_data    : r_wdata;
  assign w_is_write = w_fast ? w_is_write_in : r_is_write;
  assign w_valid    = w_fast ? w_valid_in    : r_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_is_write  <= 1'b0;
      r_valid     <= 1'b0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
      r_read_data <= 32'd0;
    end else begin
      r_ready <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_strobe) begin
            r_idx      <= w_idx_in;
            r_wdata    <= write_data;
            r_is_write <= w_is_write_in;
            r_valid    <= w_valid_in;
            r_cnt      <= LP_WAIT;
            r_busy     <= 1'b1;
            if (LP_WAIT == 4'd0) r_state <= ST_DONE;
            else                 r_state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
      if (w_done_en) begin
        r_ready <= 1'b1;
        r_error <= !w_valid;
        if (w_valid && !w_is_write) r_read_data <= r_mem[w_idx];
      end
    end
  end

  // Storage is never cleared; a reset on the completion edge suppresses the write.
  always_ff @(posedge clock) begin
    if (!reset && w_done_en && w_valid && w_is_write) r_mem[w_idx] <= w_wdata;
  end

  assign read_data = r_read_data;
  assign ready     = r_ready;
  assign busy      = r_busy;
  assign error     = r_error;

endmodule

// File: tb/tb_unified_memory_responder.sv
// Directed bench for unified_memory_responder using instances with 0, 1 and 3 wait states.
module tb_unified_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, write_data;
  logic        rd0, wr0, rd1, wr1, rd3, wr3;
  logic [31:0] rdata0, rdata1, rdata3;
  logic        ready0, ready1, ready3;
  logic        busy0, busy1, busy3;
  logic        err0, err1, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clock(clk), .reset(reset), .MemRead(rd0), .MemWrite(wr0), .address(address),
    .write_data(write_data), .read_data(rdata0), .ready(ready0), .busy(busy0), .error(err0));
  unified_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut1 (
    .clock(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .address(address),
    .write_data(write_data), .read_data(rdata1), .ready(ready1), .busy(busy1), .error(err1));
  unified_memory_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3)) dut3 (
    .clock(clk), .reset(reset), .MemRead(rd3), .MemWrite(wr3), .address(address),
    .write_data(write_data), .read_data(rdata3), .ready(ready3), .busy(busy3), .error(err3));

  function automatic logic get_ready(input int sel);
    case (sel)
      0:       return ready0;
      1:       return ready1;
      default: return ready3;
    endcase
  endfunction

  // Present a request for exactly one rising edge, then drop the strobes.
  task automatic issue(input int sel, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    write_data = d;
    case (sel)
      0:       begin rd0 = r; wr0 = w; end
      1:       begin rd1 = r; wr1 = w; end
      default: begin rd3 = r; wr3 = w; end
    endcase
    @(negedge clk);
    rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0; rd3 = 0; wr3 = 0;
  endtask

  // Cycles from the first sample after acceptance until ready; 20 means timeout.
  task automatic wait_ready(input int sel, output int k);
    k = 0;
    while (get_ready(sel) !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rd0 = 0; wr0 = 0; rd1 = 1; wr1 = 0; rd3 = 0; wr3 = 0;
    address = 32'h0; write_data = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdata0, rdata1, rdata3} !== 96'd0) begin
      errors++; $display("FAIL reset_read_data: got %h %h %h, want 0", rdata0, rdata1, rdata3);
    end
    checks++;
    if ({ready0, ready1, ready3, busy0, busy1, busy3, err0, err1, err3} !== 9'd0) begin
      errors++; $display("FAIL reset_flags: got r%b%b%b b%b%b%b e%b%b%b, want all 0",
                         ready0, ready1, ready3, busy0, busy1, busy3, err0, err1, err3);
    end
    reset = 1'b0;
    rd1 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL reset_strobe_ignored: busy=%b, want 0", busy1);
    end
  endtask

  task automatic test_read;
    int k;
    issue(1, 0, 1, 32'h0000_000C, 32'hDEAD_BEEF);
    wait_ready(1, k);
    @(negedge clk);
    issue(1, 1, 0, 32'h0000_000C, 32'h0);
    checks++;
    if (busy1 !== 1'b1 || ready1 !== 1'b0) begin
      errors++; $display("FAIL read_busy_phase: busy=%b ready=%b, want 1 0", busy1, ready1);
    end
    wait_ready(1, k);
    checks++;
    if (k !== 1) begin
      errors++; $display("FAIL read_latency: got %0d, want 1", k);
    end
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF || err1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL read_data: got %h err=%b busy=%b, want deadbeef 0 1", rdata1, err1, busy1);
    end
    @(negedge clk);
    checks++;
    if (ready1 !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL read_pulse_end: ready=%b busy=%b, want 0 0", ready1, busy1);
    end
  endtask

  task automatic test_write_read;
    int k;
    issue(1, 0, 1, 32'h0000_0010, 32'h1234_5678);
    wait_ready(1, k);
    checks++;
    if (k !== 1 || err1 !== 1'b0 || rdata1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_done: lat=%0d err=%b rdata=%h, want 1 0 deadbeef", k, err1, rdata1);
    end
    @(negedge clk);
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL write_keeps_rdata: got %h, want deadbeef", rdata1);
    end
    issue(1, 1, 0, 32'h0000_0010, 32'h0);
    wait_ready(1, k);
    checks++;
    if (rdata1 !== 32'h1234_5678 || err1 !== 1'b0) begin
      errors++; $display("FAIL raw_read: got %h err=%b, want 12345678 0", rdata1, err1);
    end
    @(negedge clk);
  endtask

  task automatic test_errors;
    int k;
    logic [31:0] addrs [4];
    logic        rds [4];
    logic        wrs [4];
    addrs = '{32'h0000_000E, 32'h0000_0400, 32'h0000_000C, 32'h0000_0012};
    rds   = '{1'b1, 1'b1, 1'b1, 1'b0};
    wrs   = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(1, rds[i], wrs[i], addrs[i], 32'hFFFF_FFFF);
      wait_ready(1, k);
      checks++;
      if (k !== 1 || err1 !== 1'b1 || rdata1 !== 32'h1234_5678) begin
        errors++; $display("FAIL error_case%0d: lat=%0d err=%b rdata=%h, want 1 1 12345678",
                           i, k, err1, rdata1);
      end
      @(negedge clk);
    end
    issue(1, 1, 0, 32'h0000_000C, 32'h0);
    wait_ready(1, k);
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL error_storage_c: got %h, want deadbeef", rdata1);
    end
    @(negedge clk);
    issue(1, 1, 0, 32'h0000_0010, 32'h0);
    wait_ready(1, k);
    checks++;
    if (rdata1 !== 32'h1234_5678) begin
      errors++; $display("FAIL error_storage_10: got %h, want 12345678", rdata1);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int k;
    int pulses = 0;
    issue(0, 0, 1, 32'h0000_0000, 32'hCAFE_F00D);
    wait_ready(0, k);
    checks++;
    if (k !== 0 || err0 !== 1'b0) begin
      errors++; $display("FAIL ws0_write: lat=%0d err=%b, want 0 0", k, err0);
    end
    @(negedge clk);
    address = 32'h0;
    rd0     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready0 === 1'b1) pulses++;
      checks++;
      if (ready0 !== ((i % 2) == 0) || busy0 !== ((i % 2) == 0)) begin
        errors++; $display("FAIL held_read_cycle%0d: ready=%b busy=%b, want %b", i, ready0, busy0,
                           ((i % 2) == 0));
      end
    end
    rd0 = 1'b0;
    checks++;
    if (pulses !== 5 || rdata0 !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL held_read_total: pulses=%0d rdata=%h, want 5 cafef00d", pulses, rdata0);
    end
    @(negedge clk);
  endtask

  task automatic test_addr_change;
    int k;
    issue(3, 0, 1, 32'h0000_0004, 32'h1111_1111);
    wait_ready(3, k);
    @(negedge clk);
    issue(3, 0, 1, 32'h0000_0008, 32'h2222_2222);
    wait_ready(3, k);
    @(negedge clk);
    issue(3, 1, 0, 32'h0000_0004, 32'h0);
    address = 32'h0000_0008;
    rd3     = 1'b1;
    wait_ready(3, k);
    rd3     = 1'b0;
    checks++;
    if (k !== 3 || rdata3 !== 32'h1111_1111 || err3 !== 1'b0) begin
      errors++; $display("FAIL addr_change: lat=%0d rdata=%h err=%b, want 3 11111111 0", k, rdata3, err3);
    end
    @(negedge clk);
    issue(3, 1, 0, 32'h0000_0008, 32'h0);
    wait_ready(3, k);
    checks++;
    if (rdata3 !== 32'h2222_2222) begin
      errors++; $display("FAIL addr_word2: got %h, want 22222222", rdata3);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_during_write;
    int k;
    int seen = 0;
    issue(1, 0, 1, 32'h0000_0020, 32'hAAAA_5555);
    wait_ready(1, k);
    @(negedge clk);
    issue(1, 0, 1, 32'h0000_0020, 32'h5555_AAAA);
    reset = 1'b1;
    @(negedge clk);
    if (ready1 === 1'b1) seen++;
    checks++;
    if (busy1 !== 1'b0 || ready1 !== 1'b0) begin
      errors++; $display("FAIL reset_abort_state: busy=%b ready=%b, want 0 0", busy1, ready1);
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ready1 === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_abort_ready: pulses=%0d, want 0", seen);
    end
    issue(1, 1, 0, 32'h0000_0020, 32'h0);
    wait_ready(1, k);
    checks++;
    if (rdata1 !== 32'hAAAA_5555) begin
      errors++; $display("FAIL reset_abort_storage: got %h, want aaaa5555", rdata1);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_addr_change();
    test_reset_during_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
